// File: rtl/lcd_pattern_gen.sv
// RGB565 test-pattern source re-aligning DE/HSYNC/VSYNC with a fixed 2-cycle latency.
// Optional macro PATTERN_ANIM_EN scrolls the colour bars left by one pixel per frame.
module lcd_pattern_gen #(
  parameter int H_ACTIVE        = 480,
  parameter int V_ACTIVE        = 272,
  parameter bit SYNC_POL        = 1'b0,
  parameter bit BTN_ACTIVE_LOW  = 1'b1,
  parameter int DEBOUNCE_CYCLES = 90000
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       BTN,
  input  logic       IN_DE,
  input  logic       IN_HSYNC,
  input  logic       IN_VSYNC,
  output logic       LCD_DE,
  output logic       LCD_HSYNC,
  output logic       LCD_VSYNC,
  output logic [4:0] LCD_R,
  output logic [5:0] LCD_G,
  output logic [4:0] LCD_B,
  output logic [1:0] PATTERN
);

  localparam int              CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [9:0]      X_LAST  = 10'(H_ACTIVE - 1);
  localparam logic [9:0]      Y_LAST  = 10'(V_ACTIVE - 1);
  localparam logic [9:0]      BAR_W   = 10'(H_ACTIVE / 8);

  typedef enum logic {BTN_IDLE, BTN_PRESSED} btn_state_t;

  btn_state_t       btn_state, btn_next;
  logic [1:0]       btn_sync;
  logic             btn_pressed;
  logic [CNT_W-1:0] db_cnt, db_cnt_next;
  logic             press_evt;
  logic [1:0]       pending, pattern;

  logic       de1, hs1, vs1;
  logic [9:0] x1, y1, x_next, y_next;
  logic       vs_edge, de_fall;

  logic [9:0] bar_x, bar_idx;
  logic [2:0] bar;
  logic       grid_on;
  logic [4:0] pix_r, pix_b;
  logic [5:0] pix_g;

  logic       de2, hs2, vs2;
  logic [4:0] r2, b2;
  logic [5:0] g2;

  always_ff @(posedge CLK) begin
    if (RST) btn_sync <= {2{BTN_ACTIVE_LOW}};
    else     btn_sync <= {btn_sync[0], BTN};
  end

  assign btn_pressed = btn_sync[1] ^ BTN_ACTIVE_LOW;

  always_ff @(posedge CLK) begin
    if (RST) begin
      btn_state <= BTN_IDLE;
      db_cnt    <= '0;
    end else begin
      btn_state <= btn_next;
      db_cnt    <= db_cnt_next;
    end
  end

  // A level is accepted only after it has differed from the current state for DEBOUNCE_CYCLES samples
  always_comb begin
    btn_next    = btn_state;
    db_cnt_next = '0;
    press_evt   = 1'b0;
    if (btn_pressed != (btn_state == BTN_PRESSED)) begin
      if (db_cnt == DB_LAST) begin
        btn_next  = btn_pressed ? BTN_PRESSED : BTN_IDLE;
        press_evt = btn_pressed;
      end else begin
        db_cnt_next = db_cnt + 1'b1;
      end
    end
  end

  assign vs_edge = (IN_VSYNC == SYNC_POL) && (vs1 != SYNC_POL);
  assign de_fall = de1 && !IN_DE;

  // Pattern changes are held back to the frame boundary so a frame never tears
  always_ff @(posedge CLK) begin
    if (RST) begin
      pending <= '0;
      pattern <= '0;
    end else begin
      if (press_evt) pending <= pending + 1'b1;
      if (vs_edge)   pattern <= pending;
    end
  end

  always_comb begin
    x_next = '0;
    if (IN_DE && de1) x_next = (x1 == X_LAST) ? x1 : x1 + 1'b1;
    y_next = y1;
    if (vs_edge)      y_next = '0;
    else if (de_fall) y_next = (y1 == Y_LAST) ? y1 : y1 + 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      de1 <= 1'b0;
      hs1 <= ~SYNC_POL;
      vs1 <= ~SYNC_POL;
      x1  <= '0;
      y1  <= '0;
    end else begin
      de1 <= IN_DE;
      hs1 <= IN_HSYNC;
      vs1 <= IN_VSYNC;
      x1  <= x_next;
      y1  <= y_next;
    end
  end

`ifdef PATTERN_ANIM_EN
  localparam logic [9:0] H_SIZE = 10'(H_ACTIVE);
  logic [8:0] offset;
  logic [9:0] x_sum;

  always_ff @(posedge CLK) begin
    if (RST)          offset <= '0;
    else if (vs_edge) offset <= (offset == X_LAST[8:0]) ? 9'd0 : offset + 1'b1;
  end

  always_comb begin
    x_sum = x1 + {1'b0, offset};
    bar_x = (x_sum >= H_SIZE) ? x_sum - H_SIZE : x_sum;
  end
`else
  assign bar_x = x1;
`endif

  assign bar_idx = bar_x / BAR_W;
  assign bar     = (bar_idx > 10'd7) ? 3'd7 : bar_idx[2:0];
  assign grid_on = (x1[4:0] == 5'd0) || (y1[4:0] == 5'd0) || (x1 == X_LAST) || (y1 == Y_LAST);

  // Bar order white..black falls out of inverting the bar index bits per channel
  always_comb begin
    pix_r = '0;
    pix_g = '0;
    pix_b = '0;
    case (pattern)
      2'd0: begin
        pix_r = {5{~bar[1]}};
        pix_g = {6{~bar[2]}};
        pix_b = {5{~bar[0]}};
      end
      2'd1: begin
        pix_r = {5{grid_on}};
        pix_g = {6{grid_on}};
        pix_b = {5{grid_on}};
      end
      2'd2: begin
        pix_r = x1[8:4];
        pix_g = y1[8:3];
        pix_b = ~x1[8:4];
      end
      default: begin
        pix_r = '1;
        pix_g = '1;
        pix_b = '1;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      de2 <= 1'b0;
      hs2 <= ~SYNC_POL;
      vs2 <= ~SYNC_POL;
      r2  <= '0;
      g2  <= '0;
      b2  <= '0;
    end else begin
      de2 <= de1;
      hs2 <= hs1;
      vs2 <= vs1;
      r2  <= de1 ? pix_r : 5'd0;
      g2  <= de1 ? pix_g : 6'd0;
      b2  <= de1 ? pix_b : 5'd0;
    end
  end

  assign LCD_DE    = de2;
  assign LCD_HSYNC = hs2;
  assign LCD_VSYNC = vs2;
  assign LCD_R     = r2;
  assign LCD_G     = g2;
  assign LCD_B     = b2;
  assign PATTERN   = pattern;

endmodule

// File: tb/tb_lcd_pattern_gen.sv
// Directed bench for lcd_pattern_gen: drives 480-wide frames, captures pixels and
// compares sync alignment, pattern contents and button/frame-boundary behaviour.
module tb_lcd_pattern_gen;

  logic       CLK = 1'b0;
  logic       RST, BTN, IN_DE, IN_HSYNC, IN_VSYNC;
  logic       LCD_DE, LCD_HSYNC, LCD_VSYNC;
  logic [4:0] LCD_R, LCD_B;
  logic [5:0] LCD_G;
  logic [1:0] PATTERN;

  int errors    = 0;
  int checks    = 0;
  int sync_bad  = 0;
  int frame_cnt = 0;

  logic prev_de, prev_hs, prev_vs;
  int   prev_x, prev_y;
  logic [15:0] fb [128][480];

  always #5 CLK = ~CLK;

  lcd_pattern_gen #(
    .H_ACTIVE(480), .V_ACTIVE(272), .SYNC_POL(1'b0),
    .BTN_ACTIVE_LOW(1'b1), .DEBOUNCE_CYCLES(200)
  ) dut (
    .CLK(CLK), .RST(RST), .BTN(BTN),
    .IN_DE(IN_DE), .IN_HSYNC(IN_HSYNC), .IN_VSYNC(IN_VSYNC),
    .LCD_DE(LCD_DE), .LCD_HSYNC(LCD_HSYNC), .LCD_VSYNC(LCD_VSYNC),
    .LCD_R(LCD_R), .LCD_G(LCD_G), .LCD_B(LCD_B), .PATTERN(PATTERN)
  );

  // Expected colour bar for pixel x given the scroll offset of the current frame
  function automatic logic [15:0] bar_color(input int x);
    int off, p;
`ifdef PATTERN_ANIM_EN
    off = frame_cnt % 480;
`else
    off = 0;
`endif
    p = (x + off) % 480;
    case (p / 60)
      0: return 16'hFFFF;
      1: return 16'hFFE0;
      2: return 16'h07FF;
      3: return 16'h07E0;
      4: return 16'hF81F;
      5: return 16'hF800;
      6: return 16'h001F;
      default: return 16'h0000;
    endcase
  endfunction

  // One pixel-clock cycle: outputs seen now must equal the inputs of the previous step
  task automatic step(input logic rst, input logic de, input logic hs, input logic vs,
                      input int sx, input int sy);
    logic exp_de, exp_hs, exp_vs;
    RST = rst; IN_DE = de; IN_HSYNC = hs; IN_VSYNC = vs;
    @(posedge CLK); #1;
    if (rst) begin
      exp_de = 1'b0; exp_hs = 1'b1; exp_vs = 1'b1;
    end else begin
      exp_de = prev_de; exp_hs = prev_hs; exp_vs = prev_vs;
    end
    if (LCD_DE !== exp_de || LCD_HSYNC !== exp_hs || LCD_VSYNC !== exp_vs) sync_bad++;
    if (!LCD_DE && {LCD_R, LCD_G, LCD_B} !== 16'h0000) sync_bad++;
    if (!rst && prev_de && prev_y < 128 && prev_x < 480)
      fb[prev_y][prev_x] = {LCD_R, LCD_G, LCD_B};
    if (rst) begin
      prev_de = 1'b0; prev_hs = 1'b1; prev_vs = 1'b1;
    end else begin
      prev_de = de; prev_hs = hs; prev_vs = vs;
    end
    prev_x = sx; prev_y = sy;
  endtask

  task automatic run_line(input int l);
    repeat (4) step(1'b0, 1'b0, 1'b0, 1'b1, 0, 0);
    repeat (6) step(1'b0, 1'b0, 1'b1, 1'b1, 0, 0);
    for (int x = 0; x < 480; x++) step(1'b0, 1'b1, 1'b1, 1'b1, x, l);
    repeat (6) step(1'b0, 1'b0, 1'b1, 1'b1, 0, 0);
  endtask

  task automatic run_frame(input int nlines);
    frame_cnt++;
    repeat (4) step(1'b0, 1'b0, 1'b1, 1'b0, 0, 0);
    repeat (8) step(1'b0, 1'b0, 1'b1, 1'b1, 0, 0);
    for (int l = 0; l < nlines; l++) run_line(l);
  endtask

  task automatic press_button(input int delay, input int hold, input int gap);
    repeat (delay) @(negedge CLK);
    BTN = 1'b0;
    repeat (hold) @(negedge CLK);
    BTN = 1'b1;
    repeat (gap) @(negedge CLK);
  endtask

  task automatic test_reset;
    BTN = 1'b1;
    repeat (3) step(1'b1, 1'b0, 1'b1, 1'b1, 0, 0);
    checks++;
    if (LCD_DE !== 1'b0) begin errors++; $display("[TB] FAIL reset_de: got %b, expected 0", LCD_DE); end
    checks++;
    if ({LCD_HSYNC, LCD_VSYNC} !== 2'b11) begin
      errors++; $display("[TB] FAIL reset_sync: got %b, expected 11", {LCD_HSYNC, LCD_VSYNC});
    end
    checks++;
    if ({LCD_R, LCD_G, LCD_B} !== 16'h0000) begin
      errors++; $display("[TB] FAIL reset_rgb: got %h, expected 0000", {LCD_R, LCD_G, LCD_B});
    end
    checks++;
    if (PATTERN !== 2'd0) begin errors++; $display("[TB] FAIL reset_pattern: got %0d, expected 0", PATTERN); end
    repeat (4) step(1'b0, 1'b0, 1'b1, 1'b1, 0, 0);
  endtask

  task automatic test_bars;
    int xs[7] = '{0, 59, 60, 119, 240, 420, 479};
    run_frame(2);
    for (int i = 0; i < 7; i++) begin
      checks++;
      if (fb[0][xs[i]] !== bar_color(xs[i])) begin
        errors++;
        $display("[TB] FAIL bars x=%0d: got %h, expected %h", xs[i], fb[0][xs[i]], bar_color(xs[i]));
      end
    end
    checks++;
    if (fb[1][130] !== bar_color(130)) begin
      errors++; $display("[TB] FAIL bars_line1: got %h, expected %h", fb[1][130], bar_color(130));
    end
    checks++;
    if (sync_bad !== 0) begin errors++; $display("[TB] FAIL bars_sync: got %0d bad cycles, expected 0", sync_bad); end
    sync_bad = 0;
  endtask

  task automatic test_anim_scroll;
    logic [15:0] exp;
`ifdef PATTERN_ANIM_EN
    exp = 16'hFFE0;
`else
    exp = 16'hFFFF;
`endif
    run_frame(2);
    checks++;
    if (fb[0][58] !== exp) begin errors++; $display("[TB] FAIL scroll_px58: got %h, expected %h", fb[0][58], exp); end
  endtask

  task automatic test_button_glitch;
    BTN = 1'b0;
    repeat (20) step(1'b0, 1'b0, 1'b1, 1'b1, 0, 0);
    BTN = 1'b1;
    repeat (10) step(1'b0, 1'b0, 1'b1, 1'b1, 0, 0);
    run_frame(2);
    checks++;
    if (PATTERN !== 2'd0) begin errors++; $display("[TB] FAIL glitch_pattern: got %0d, expected 0", PATTERN); end
    checks++;
    if (sync_bad !== 0) begin errors++; $display("[TB] FAIL glitch_sync: got %0d bad cycles, expected 0", sync_bad); end
    sync_bad = 0;
  endtask

  task automatic test_press_midframe;
    fork
      run_frame(3);
      begin
        press_button(100, 400, 300);
        checks++;
        if (PATTERN !== 2'd0) begin errors++; $display("[TB] FAIL midframe_hold: got %0d, expected 0", PATTERN); end
      end
    join
    checks++;
    if (PATTERN !== 2'd0) begin errors++; $display("[TB] FAIL frame_end_hold: got %0d, expected 0", PATTERN); end
  endtask

  task automatic test_grid;
    run_frame(101);
    checks++;
    if (PATTERN !== 2'd1) begin errors++; $display("[TB] FAIL grid_pattern: got %0d, expected 1", PATTERN); end
    checks++;
    if (fb[0][0] !== 16'hFFFF) begin errors++; $display("[TB] FAIL grid_0_0: got %h, expected FFFF", fb[0][0]); end
    checks++;
    if (fb[1][1] !== 16'h0000) begin errors++; $display("[TB] FAIL grid_1_1: got %h, expected 0000", fb[1][1]); end
    checks++;
    if (fb[5][32] !== 16'hFFFF) begin errors++; $display("[TB] FAIL grid_32_5: got %h, expected FFFF", fb[5][32]); end
    checks++;
    if (fb[5][33] !== 16'h0000) begin errors++; $display("[TB] FAIL grid_33_5: got %h, expected 0000", fb[5][33]); end
    checks++;
    if (fb[100][479] !== 16'hFFFF) begin errors++; $display("[TB] FAIL grid_479_100: got %h, expected FFFF", fb[100][479]); end
    checks++;
    if (sync_bad !== 0) begin errors++; $display("[TB] FAIL grid_sync: got %0d bad cycles, expected 0", sync_bad); end
    sync_bad = 0;
  endtask

  task automatic test_gradient;
    fork
      run_frame(2);
      press_button(100, 400, 10);
    join
    // Four full presses inside the gradient frame must wrap the pending pattern back to 2
    fork
      run_frame(9);
      begin
        repeat (50) @(negedge CLK);
        for (int i = 0; i < 4; i++) press_button(0, 250, 250);
      end
    join
    checks++;
    if (PATTERN !== 2'd2) begin errors++; $display("[TB] FAIL grad_pattern: got %0d, expected 2", PATTERN); end
    checks++;
    if (fb[8][100] !== 16'h3039) begin errors++; $display("[TB] FAIL grad_100_8: got %h, expected 3039", fb[8][100]); end
    checks++;
    if (fb[1][479] !== 16'hE802) begin errors++; $display("[TB] FAIL grad_479_1: got %h, expected E802", fb[1][479]); end
    checks++;
    if (fb[0][0] !== 16'h001F) begin errors++; $display("[TB] FAIL grad_0_0: got %h, expected 001F", fb[0][0]); end
  endtask

  task automatic test_back_to_back;
    run_frame(2);
    checks++;
    if (PATTERN !== 2'd2) begin errors++; $display("[TB] FAIL wrap_pattern: got %0d, expected 2", PATTERN); end
    checks++;
    if (fb[1][100] !== 16'h3019) begin errors++; $display("[TB] FAIL wrap_100_1: got %h, expected 3019", fb[1][100]); end
    checks++;
    if (sync_bad !== 0) begin errors++; $display("[TB] FAIL wrap_sync: got %0d bad cycles, expected 0", sync_bad); end
    sync_bad = 0;
  endtask

  task automatic test_reset_midline;
    repeat (4) step(1'b0, 1'b0, 1'b1, 1'b0, 0, 0);
    repeat (8) step(1'b0, 1'b0, 1'b1, 1'b1, 0, 0);
    repeat (4) step(1'b0, 1'b0, 1'b0, 1'b1, 0, 0);
    repeat (6) step(1'b0, 1'b0, 1'b1, 1'b1, 0, 0);
    for (int x = 0; x < 200; x++) step(1'b0, 1'b1, 1'b1, 1'b1, x, 0);
    step(1'b1, 1'b1, 1'b1, 1'b1, 0, 0);
    checks++;
    if (LCD_DE !== 1'b0) begin errors++; $display("[TB] FAIL midrst_de: got %b, expected 0", LCD_DE); end
    checks++;
    if ({LCD_R, LCD_G, LCD_B} !== 16'h0000) begin
      errors++; $display("[TB] FAIL midrst_rgb: got %h, expected 0000", {LCD_R, LCD_G, LCD_B});
    end
    checks++;
    if ({LCD_HSYNC, LCD_VSYNC} !== 2'b11) begin
      errors++; $display("[TB] FAIL midrst_sync: got %b, expected 11", {LCD_HSYNC, LCD_VSYNC});
    end
    checks++;
    if (PATTERN !== 2'd0) begin errors++; $display("[TB] FAIL midrst_pattern: got %0d, expected 0", PATTERN); end
    frame_cnt = 0;
    for (int x = 201; x < 480; x++) step(1'b0, 1'b1, 1'b1, 1'b1, x - 201, 0);
    repeat (6) step(1'b0, 1'b0, 1'b1, 1'b1, 0, 0);
    run_frame(2);
    checks++;
    if (fb[0][0] !== bar_color(0)) begin errors++; $display("[TB] FAIL post_rst_x0: got %h, expected %h", fb[0][0], bar_color(0)); end
    checks++;
    if (fb[1][300] !== bar_color(300)) begin
      errors++; $display("[TB] FAIL post_rst_x300: got %h, expected %h", fb[1][300], bar_color(300));
    end
    checks++;
    if (fb[0][479] !== bar_color(479)) begin
      errors++; $display("[TB] FAIL post_rst_x479: got %h, expected %h", fb[0][479], bar_color(479));
    end
    checks++;
    if (sync_bad !== 0) begin errors++; $display("[TB] FAIL midrst_align: got %0d bad cycles, expected 0", sync_bad); end
    sync_bad = 0;
  endtask

  initial begin
    RST = 1'b1; BTN = 1'b1; IN_DE = 1'b0; IN_HSYNC = 1'b1; IN_VSYNC = 1'b1;
    prev_de = 1'b0; prev_hs = 1'b1; prev_vs = 1'b1; prev_x = 0; prev_y = 0;
    test_reset;
    test_bars;
    test_anim_scroll;
    test_button_glitch;
    test_press_midframe;
    test_grid;
    test_gradient;
    test_back_to_back;
    test_reset_midline;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
